// File: rtl/disp_hole_fill.sv
// Disparity hole filler: replaces invalid (0) pixels with the smaller
// of the nearest valid left value and a bounded-window right value.
module disp_hole_fill #(
  parameter int D = 64,
  parameter int W = 640,
  parameter int G = 8,
  localparam int NBIT = $clog2(D),
  localparam int CW = (W > 1) ? $clog2(W) : 1,
  localparam int GW = $clog2(G + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_dval,
  input  logic [NBIT-1:0] i_data,
  input  logic            i_fill_en,
  output logic            o_dval,
  output logic [NBIT-1:0] o_data,
  output logic            o_filled
);

  typedef struct packed {
    logic [NBIT-1:0] d;
    logic            sol;
    logic            rk;
    logic [NBIT-1:0] r;
  } ent_t;

  ent_t            dl    [G];
  ent_t            nx    [G];
  logic [CW-1:0]   col;
  logic [GW-1:0]   cnt;
  logic            lk;
  logic [NBIT-1:0] l;
  logic            run;

  ent_t            p;
  logic            lk_eff;
  logic [NBIT-1:0] fv;
  logic [NBIT-1:0] od_nx;
  logic            of_nx;

  // Shift, then walk the new valid value back over the trailing holes
  always_comb begin
    nx[0] = '{d: i_data, sol: (col == '0), rk: 1'b0, r: '0};
    for (int j = 1; j < G; j++) begin
      nx[j] = dl[j-1];
    end
    run = (i_data != '0) && (col != '0);
    for (int j = 1; j < G; j++) begin
      if (run) begin
        if (nx[j].d != '0) begin
          run = 1'b0;
        end else begin
          nx[j].rk = 1'b1;
          nx[j].r  = i_data;
          if (nx[j].sol) begin
            run = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    p      = dl[G-1];
    lk_eff = lk & ~p.sol;
    unique case ({lk_eff, p.rk})
      2'b11:   fv = (l < p.r) ? l : p.r;
      2'b10:   fv = l;
      2'b01:   fv = p.r;
      default: fv = '0;
    endcase
    od_nx = '0;
    of_nx = 1'b0;
    if (p.d != '0) begin
      od_nx = p.d;
    end else if (i_fill_en) begin
      od_nx = fv;
      of_nx = (fv != '0);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int j = 0; j < G; j++) begin
        dl[j] <= '0;
      end
      col      <= '0;
      cnt      <= '0;
      lk       <= 1'b0;
      l        <= '0;
      o_dval   <= 1'b0;
      o_data   <= '0;
      o_filled <= 1'b0;
    end else if (i_dval) begin
      for (int j = 0; j < G; j++) begin
        dl[j] <= nx[j];
      end
      col      <= (col == CW'(W - 1)) ? '0 : col + 1'b1;
      o_dval   <= (cnt == GW'(G));
      if (cnt != GW'(G)) begin
        cnt <= cnt + 1'b1;
      end
      o_data   <= od_nx;
      o_filled <= of_nx;
      if (p.d != '0) begin
        lk <= 1'b1;
        l  <= p.d;
      end else if (p.sol) begin
        lk <= 1'b0;
      end
    end else begin
      o_dval <= 1'b0;
    end
  end

endmodule

// File: tb/tb_disp_hole_fill.sv
// Scoreboard bench for disp_hole_fill: a per-row reference model pushes
// expected pixels, the output monitor pops them on every o_dval.
module tb_disp_hole_fill;

  localparam int D = 64;
  localparam int W = 8;
  localparam int G = 4;
  localparam int NBIT = 6;

  typedef logic [NBIT-1:0] row_t [W];
  typedef struct {
    logic [NBIT-1:0] d_f;
    logic            f_f;
    logic [NBIT-1:0] d_b;
  } exp_t;

  logic            clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_dval = 1'b0;
  logic [NBIT-1:0] i_data = '0;
  logic            i_fill_en = 1'b1;
  logic            o_dval;
  logic [NBIT-1:0] o_data;
  logic            o_filled;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   adv_cnt = 0;
  int   dval_cnt = 0;

  disp_hole_fill #(.D(D), .W(W), .G(G)) dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_dval   (i_dval),
    .i_data   (i_data),
    .i_fill_en(i_fill_en),
    .o_dval   (o_dval),
    .o_data   (o_data),
    .o_filled (o_filled)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic void model(input row_t r);
    exp_t e;
    logic lk, rk;
    int   lv, rv, v;
    for (int c = 0; c < W; c++) begin
      if (r[c] != 0) begin
        e.d_f = r[c];
        e.f_f = 1'b0;
        e.d_b = r[c];
      end else begin
        lk = 1'b0; rk = 1'b0; lv = 0; rv = 0;
        for (int j = c - 1; j >= 0; j--) begin
          if (!lk && r[j] != 0) begin
            lk = 1'b1; lv = r[j];
          end
        end
        for (int k = c + 1; k < W && k - c <= G - 1; k++) begin
          if (!rk && r[k] != 0) begin
            rk = 1'b1; rv = r[k];
          end
        end
        if (lk && rk) v = (lv < rv) ? lv : rv;
        else if (lk) v = lv;
        else if (rk) v = rv;
        else v = 0;
        e.d_f = NBIT'(v);
        e.f_f = (v != 0);
        e.d_b = '0;
      end
      q.push_back(e);
    end
  endfunction

  task automatic monitor();
    exp_t e;
    if (i_rst) return;
    if (i_dval) begin
      if (adv_cnt <= G) chk("warmup_dval", o_dval, 0);
      else chk("run_dval", o_dval, 1);
    end else begin
      chk("stall_dval", o_dval, 0);
    end
    if (o_dval) begin
      dval_cnt++;
      if (q.size() == 0) begin
        chk("sb_empty", q.size(), 1);
      end else begin
        e = q.pop_front();
        if (i_fill_en) begin
          chk("data", o_data, e.d_f);
          chk("filled", o_filled, e.f_f);
        end else begin
          chk("bypass_data", o_data, e.d_b);
          chk("bypass_filled", o_filled, 0);
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic [NBIT-1:0] d);
    @(negedge clk);
    monitor();
    i_dval = v;
    i_data = v ? d : '0;
    if (v) adv_cnt++;
  endtask

  task automatic send_row(input row_t r, input int duty, input int n);
    model(r);
    for (int c = 0; c < n; c++) begin
      while ($urandom_range(99) >= duty) step(1'b0, '0);
      step(1'b1, r[c]);
    end
  endtask

  function automatic row_t rnd_row();
    row_t r;
    for (int c = 0; c < W; c++) begin
      r[c] = ($urandom_range(99) < 45) ? '0 : NBIT'($urandom_range(63, 1));
    end
    return r;
  endfunction

  task automatic do_reset();
    #2;
    i_rst  = 1'b1;
    i_dval = 1'b0;
    i_data = '0;
    #1;
    chk("rst_dval", o_dval, 0);
    chk("rst_data", o_data, 0);
    chk("rst_filled", o_filled, 0);
    q.delete();
    adv_cnt  = 0;
    dval_cnt = 0;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
  endtask

  row_t r_int  = '{6'd5, 6'd0, 6'd0, 6'd7, 6'd7, 6'd7, 6'd7, 6'd7};
  row_t r_edge = '{6'd0, 6'd0, 6'd9, 6'd9, 6'd9, 6'd9, 6'd4, 6'd0};
  row_t r_leak = '{6'd0, 6'd3, 6'd0, 6'd2, 6'd0, 6'd0, 6'd0, 6'd0};
  row_t r_gap  = '{6'd6, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd3, 6'd3};
  row_t r_one  = '{6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1};

  initial begin
    repeat (3) @(negedge clk);
    chk("por_dval", o_dval, 0);
    chk("por_data", o_data, 0);
    chk("por_filled", o_filled, 0);
    i_rst = 1'b0;

    send_row(r_int, 100, W);
    send_row(r_edge, 100, W);
    send_row(r_leak, 100, W);
    send_row(r_gap, 100, W);
    repeat (4) send_row(rnd_row(), 100, W);

    send_row(r_int, 40, W);
    send_row(r_int, 40, W);
    repeat (3) send_row(rnd_row(), 40, W);

    i_fill_en = 1'b0;
    send_row(r_int, 100, W);
    send_row(rnd_row(), 70, W);
    i_fill_en = 1'b1;

    send_row(rnd_row(), 100, 3);
    do_reset();

    send_row(r_int, 100, W);
    send_row(r_gap, 60, W);
    send_row(r_edge, 100, W);
    repeat (2) send_row(rnd_row(), 50, W);
    send_row(r_one, 100, W);
    repeat (3) step(1'b0, '0);
    chk("dval_count", dval_cnt, adv_cnt - G);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/disp_hole_fill.md
# disp_hole_fill

Streaming post-filter placed directly after the left-right consistency check stage. It consumes the disparity stream, in which 0 marks an invalid or occluded pixel. Each invalid pixel is replaced with a background estimate: the smaller of the nearest valid disparity to its left and the nearest valid disparity to its right, both taken from the same image row. The right neighbour is only considered within a bounded look-ahead window. The block uses the same i_dval-gated advance model as the rest of the disparity pipeline.

## Interface
- D, 64: disparity range; NBIT = $clog2(D).
- W, 640: row width in pixels; W ≥ 2.
- G, 8: look-ahead depth (delay-line entries); 2 ≤ G ≤ W.
- i_clk  in  1  clock; every register updates on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_dval  in  1  input pixel valid; this is the only advance enable.
- i_data  in  NBIT  disparity; the value 0 means invalid.
- i_fill_en  in  1  1 = fill holes; 0 = pass holes through as 0. Sampled at output time.
- o_dval  out  1  output valid.
- o_data  out  NBIT  filled disparity.
- o_filled  out  1  1 = o_data was substituted for an input 0.

## Operation
- **Advance:** a cycle with i_dval=1. Nothing changes on other cycles except o_dval, which drops to 0.
- **Column counter col:**
  - Counts 0..W-1 on each advance and wraps to 0.
  - The incoming pixel is the start of a row (sol) when col==0.
  - Frames are treated as back-to-back rows; there is no frame marker.
- **Delay line:** G entries. Each entry holds:
  - d: NBIT bits
  - sol: 1 bit
  - rk: 1 bit, right-neighbour known
  - r: NBIT bits
- **On each advance:**
  1. Entries shift: entry j takes entry j-1.
  2. entry0 takes {i_data, col==0, 0, 0}.
  3. If i_data≠0 and col≠0, right propagation runs over the shifted entries, scanning j=1..G-1:
     - Stop at the first entry with d≠0.
     - Otherwise set rk=1 and r=i_data.
     - If that entry has sol=1, stop after updating it.
- **Output stage:** evaluates the pre-advance contents of entry G-1 (pixel p), with row-left state {lk, l}.
  - Effective left: if p.sol=1, left is treated as unknown (lk=0) for this evaluation.
  - If p.d≠0: o_data=p.d and o_filled=0.
  - If p.d=0 and i_fill_en=1:
    - both lk and p.rk set → min(l, p.r)
    - only lk set → l
    - only p.rk set → p.r
    - neither set → 0
    - o_filled=1 whenever the result is ≠0.
  - If p.d=0 and i_fill_en=0: o_data=0 and o_filled=0.
  - Left-state update:
    - If p.d≠0: lk←1 and l←p.d. Only original valid pixels update l; filled values never do.
    - Else if p.sol=1: lk←0.
- **Boundary behaviour:**
  - Holes at the start of a row take the right value only.
  - Holes at the end of a row take the left value only. Propagation never crosses a row start.
  - A hole whose right valid pixel is more than G-1 columns away gets the left value only.
- **Warm-up counter cnt:** saturates at G and counts advances.
  - On an advance: o_dval←(cnt==G), then cnt increments.
  - On a non-advance cycle: o_dval←0.
- **Reset values:**
  - o_dval=0, o_data=0, o_filled=0
  - All delay-line fields = 0; col=0; cnt=0; lk=0; l=0

## Timing
- Latency is G+1 advances: the pixel accepted on advance n is presented, with o_dval=1, in the cycle after advance n+G.
- Throughput is one pixel per advance. i_dval may deassert at any cycle with no data loss; stalls are transparent.
- The first G outputs after reset carry o_dval=0.
- Reset asserted mid-row discards all buffered pixels and restarts col at 0.
- A G-1-column look-ahead means the worst-case right-fill distance is G-1.
- All arithmetic is unsigned NBIT-bit. min() is an unsigned compare; there is no overflow path.

## Test plan
- **Reset:** assert i_rst mid-stream → all outputs 0 immediately; after release, the first G advances give o_dval=0.
- **Interior hole** (G=4, W=8, i_fill_en=1): row 5,0,0,7,7,7,7,7 → output 5,5,5,7,… with o_filled=0,1,1,0,…
- **Edge holes:** row 0,0,9,9,9,9,4,0 → 9,9,9,9,9,9,4,4 with o_filled set on columns 0, 1 and 7; no value leaks into the next row's column 0.
- **Long gap** (G=4): 6,0,0,0,0,0,3,3 → columns 1–2 give 6 (left only), columns 3–5 give min(6,3)=3; o_filled=1 on columns 1–5.
- **Stalls:** random i_dval duty of about 40% on the interior-hole row → identical output sequence; o_dval count equals the number of advances minus G.
- **Bypass:** i_fill_en=0 on the interior-hole row → 5,0,0,7,… with o_filled all 0.
